vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator and pixel pipeline. Counts a programmable

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_timing_counter.sv | 80 ++++++++
 rtl/vga_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : 640x480 timing preset, blank/total helpers and the record
//            carried by the output-alignment delay line.
// Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // 640x480 preset (36 MHz pixel clock, 832 x 509 total)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_HFP      = 32;
  localparam int VGA640_H_PULSE  = 48;
  localparam int VGA640_HBP      = 112;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_VFP      = 1;
  localparam int VGA640_V_PULSE  = 3;
  localparam int VGA640_VBP      = 25;

  // Coordinates travel through the delay line at this width; COORD_W <= 16.
  localparam int PIPE_COORD_W = 16;

  function automatic int calc_blank(input int fp, input int pulse, input int bp);
    return fp + pulse + bp;
  endfunction

  function automatic int calc_total(input int active, input int fp,
                                    input int pulse, input int bp);
    return active + calc_blank(fp, pulse, bp);
  endfunction

  // One pixel position as it must appear on the output pins.
  typedef struct packed {
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic [PIPE_COORD_W-1:0] x;
    logic [PIPE_COORD_W-1:0] y;
    logic                    frame_start;
    logic                    line_start;
`ifdef VGA_TEST_PATTERN_EN
    logic                    pat_en;
    logic [2:0]              bar;
`endif
  } vga_pipe_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_counter
// Purpose  : Horizontal/vertical position counters with sync, active-video,
//            start-of-line/frame and request-coordinate decode (stage 0).
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int HFP      = VGA640_HFP,
  parameter int H_PULSE  = VGA640_H_PULSE,
  parameter int HBP      = VGA640_HBP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int VFP      = VGA640_VFP,
  parameter int V_PULSE  = VGA640_V_PULSE,
  parameter int VBP      = VGA640_VBP,
  parameter int COORD_W  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               hsync_act_o,
  output logic               vsync_act_o,
  output logic               active_o,
  output logic               frame_start_o,
  output logic               line_start_o,
  output logic [COORD_W-1:0] req_x_o,
  output logic [COORD_W-1:0] req_y_o
);

  localparam int c_H_BLANK = calc_blank(HFP, H_PULSE, HBP);
  localparam int c_V_BLANK = calc_blank(VFP, V_PULSE, VBP);
  localparam int c_H_TOTAL = calc_total(H_ACTIVE, HFP, H_PULSE, HBP);
  localparam int c_V_TOTAL = calc_total(V_ACTIVE, VFP, V_PULSE, VBP);

  localparam logic [COORD_W-1:0] c_ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] c_H_LAST   = COORD_W'(c_H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_V_LAST   = COORD_W'(c_V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_HB       = COORD_W'(c_H_BLANK);
  localparam logic [COORD_W-1:0] c_VB       = COORD_W'(c_V_BLANK);
  localparam logic [COORD_W-1:0] c_HS_START = COORD_W'(HFP);
  localparam logic [COORD_W-1:0] c_HS_END   = COORD_W'(HFP + H_PULSE);
  localparam logic [COORD_W-1:0] c_VS_START = COORD_W'(VFP);
  localparam logic [COORD_W-1:0] c_VS_END   = COORD_W'(VFP + V_PULSE);

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

  // Next position: h wraps every line, v advances on h wrap and wraps per frame.
  always_comb begin
    h_cnt_d = h_cnt_q + c_ONE;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == c_H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == c_V_LAST) ? '0 : v_cnt_q + c_ONE;
    end
  end

  // Position registers; reset returns to the top-left blanking corner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync_act_o   = (h_cnt_q >= c_HS_START) && (h_cnt_q < c_HS_END);
  assign vsync_act_o   = (v_cnt_q >= c_VS_START) && (v_cnt_q < c_VS_END);
  assign active_o      = (h_cnt_q >= c_HB) && (v_cnt_q >= c_VB);
  assign line_start_o  = (h_cnt_q == '0);
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign req_x_o       = active_o ? (h_cnt_q - c_HB) : '0;
  assign req_y_o       = active_o ? (v_cnt_q - c_VB) : '0;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA timing generator and pixel pipeline. Issues pixel requests
//            FETCH_LATENCY cycles ahead and presents registered, mutually
//            aligned syncs/de/colour/coordinates to the DAC.
//            Optional feature macro: VGA_TEST_PATTERN_EN (8 colour bars,
//            selected per frame by test_pattern).
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE      = VGA640_H_ACTIVE,
  parameter int HFP           = VGA640_HFP,
  parameter int H_PULSE       = VGA640_H_PULSE,
  parameter int HBP           = VGA640_HBP,
  parameter int V_ACTIVE      = VGA640_V_ACTIVE,
  parameter int VFP           = VGA640_VFP,
  parameter int V_PULSE       = VGA640_V_PULSE,
  parameter int VBP           = VGA640_VBP,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int COLOR_W       = 1,
  parameter int COORD_W       = 10,
  parameter int FETCH_LATENCY = 0
) (
  input  logic                 clk_36MHz,
  input  logic                 reset,
  input  logic [3*COLOR_W-1:0] rgb_in,
  input  logic                 test_pattern,
  output logic                 req_valid,
  output logic [COORD_W-1:0]   req_x,
  output logic [COORD_W-1:0]   req_y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic [COORD_W-1:0]   x,
  output logic [COORD_W-1:0]   y,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int   c_DEPTH  = FETCH_LATENCY + 1;
  localparam logic c_HS_ON  = (HSYNC_POL != 0);
  localparam logic c_VS_ON  = (VSYNC_POL != 0);

  logic               w_hs_act, w_vs_act, w_active, w_fs, w_ls;
  logic [COORD_W-1:0] w_req_x, w_req_y;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .HFP (HFP), .H_PULSE (H_PULSE), .HBP (HBP),
    .V_ACTIVE (V_ACTIVE), .VFP (VFP), .V_PULSE (V_PULSE), .VBP (VBP),
    .COORD_W  (COORD_W)
  ) u_counter (
    .clk_i         (clk_36MHz),
    .rst_i         (reset),
    .hsync_act_o   (w_hs_act),
    .vsync_act_o   (w_vs_act),
    .active_o      (w_active),
    .frame_start_o (w_fs),
    .line_start_o  (w_ls),
    .req_x_o       (w_req_x),
    .req_y_o       (w_req_y)
  );

  assign req_valid = w_active;
  assign req_x     = w_req_x;
  assign req_y     = w_req_y;

`ifdef VGA_TEST_PATTERN_EN
  localparam int                 c_BAR_W    = H_ACTIVE / 8;
  localparam logic [COORD_W-1:0] c_BAR_LAST = COORD_W'(c_BAR_W - 1);
  localparam logic [COORD_W-1:0] c_PX_ONE   = COORD_W'(1);

  logic               tp_q;
  logic [2:0]         bar_q;
  logic [COORD_W-1:0] bar_px_q;

  // Pattern select latched at (0,0) so a frame never mixes sources; bar index
  // advances every c_BAR_W active pixels and restarts each line.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      tp_q     <= 1'b0;
      bar_q    <= '0;
      bar_px_q <= '0;
    end else begin
      if (w_fs) tp_q <= test_pattern;
      if (!w_active) begin
        bar_q    <= '0;
        bar_px_q <= '0;
      end else if (bar_px_q == c_BAR_LAST) begin
        bar_q    <= bar_q + 3'd1;
        bar_px_q <= '0;
      end else begin
        bar_px_q <= bar_px_q + c_PX_ONE;
      end
    end
  end
`endif

  vga_pipe_t w_stage0, w_pipe_rst, w_out_next;
  vga_pipe_t pipe_q [c_DEPTH];

  // Stage-0 record for the current counter position, plus the reset record.
  always_comb begin
    w_stage0             = '0;
    w_stage0.hsync       = w_hs_act ? c_HS_ON : ~c_HS_ON;
    w_stage0.vsync       = w_vs_act ? c_VS_ON : ~c_VS_ON;
    w_stage0.de          = w_active;
    w_stage0.x           = PIPE_COORD_W'(w_req_x);
    w_stage0.y           = PIPE_COORD_W'(w_req_y);
    w_stage0.frame_start = w_fs;
    w_stage0.line_start  = w_ls;
`ifdef VGA_TEST_PATTERN_EN
    w_stage0.pat_en      = tp_q;
    w_stage0.bar         = bar_q;
`endif
    w_pipe_rst           = '0;
    w_pipe_rst.hsync     = ~c_HS_ON;
    w_pipe_rst.vsync     = ~c_VS_ON;
  end

  // Delay line; its last slot is the output register for the timing signals.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) pipe_q[i] <= w_pipe_rst;
    end else begin
      pipe_q[0] <= w_stage0;
      for (int i = 1; i < c_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The entry about to land in the output slot; its colour is sampled now.
  generate
    if (FETCH_LATENCY == 0) begin : g_lat_zero
      assign w_out_next = w_stage0;
    end else begin : g_lat_pipe
      assign w_out_next = pipe_q[FETCH_LATENCY-1];
    end
  endgenerate

  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  // Colour source select; blank pixels are forced black and ignore rgb_in.
  always_comb begin
    rgb_d = '0;
    if (w_out_next.de) begin
`ifdef VGA_TEST_PATTERN_EN
      if (w_out_next.pat_en)
        rgb_d = {{COLOR_W{w_out_next.bar[2]}}, {COLOR_W{w_out_next.bar[1]}},
                 {COLOR_W{w_out_next.bar[0]}}};
      else
        rgb_d = rgb_in;
`else
      rgb_d = rgb_in;
`endif
    end
  end

  // Colour register, loaded on the same edge as the aligned timing slot.
  always_ff @(posedge clk_36MHz) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign hsync       = pipe_q[c_DEPTH-1].hsync;
  assign vsync       = pipe_q[c_DEPTH-1].vsync;
  assign de          = pipe_q[c_DEPTH-1].de;
  assign x           = COORD_W'(pipe_q[c_DEPTH-1].x);
  assign y           = COORD_W'(pipe_q[c_DEPTH-1].y);
  assign frame_start = pipe_q[c_DEPTH-1].frame_start;
  assign line_start  = pipe_q[c_DEPTH-1].line_start;
  assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1 -: COLOR_W];

  // Absorbs the port that is idle without the pattern and the spare
  // coordinate bits of the wide pipeline record.
  logic w_unused;
  assign w_unused = ^{test_pattern, pipe_q[c_DEPTH-1].x, pipe_q[c_DEPTH-1].y};

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench: small-raster timing model compared on every
//            cycle, plus hand-computed pins for sync edges, first pixel,
//            frame wrap, mid-frame reset and per-frame pattern selection.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 16, HFP = 2, H_PULSE = 3, HBP = 4;
  localparam int V_ACTIVE = 4,  VFP = 1, V_PULSE = 2, VBP = 2;
  localparam int HSYNC_POL = 1, VSYNC_POL = 0;
  localparam int COLOR_W = 1, COORD_W = 6, LAT = 2;
  localparam int HB = HFP + H_PULSE + HBP, HT = HB + H_ACTIVE;   // 9, 25
  localparam int VB = VFP + V_PULSE + VBP, VT = VB + V_ACTIVE;   // 5, 9
  localparam int FRAME = HT * VT;                                 // 225

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [2:0]         rgb_in = '0;
  logic               test_pattern = 1'b0;
  logic               req_valid, hsync, vsync, de, frame_start, line_start;
  logic [COORD_W-1:0] req_x, req_y, x, y;
  logic [COLOR_W-1:0] red, green, blue;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .HFP (HFP), .H_PULSE (H_PULSE), .HBP (HBP),
    .V_ACTIVE (V_ACTIVE), .VFP (VFP), .V_PULSE (V_PULSE), .VBP (VBP),
    .HSYNC_POL (HSYNC_POL), .VSYNC_POL (VSYNC_POL),
    .COLOR_W (COLOR_W), .COORD_W (COORD_W), .FETCH_LATENCY (LAT)
  ) dut (
    .clk_36MHz (clk), .reset (reset), .rgb_in (rgb_in),
    .test_pattern (test_pattern), .req_valid (req_valid),
    .req_x (req_x), .req_y (req_y), .hsync (hsync), .vsync (vsync),
    .de (de), .red (red), .green (green), .blue (blue), .x (x), .y (y),
    .frame_start (frame_start), .line_start (line_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;              // cycles since reset release = raster index of stage 0
  bit tp_hist [0:31];     // pattern select latched for each frame

  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  always @(posedge clk) begin
    if (!reset && (n % FRAME) == 0 && (n / FRAME) < 32)
      tp_hist[n / FRAME] = test_pattern;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Memory model: returns the request's x[2:0] exactly LAT cycles later.
  logic [COORD_W-1:0] rq [0:LAT];
  initial begin
    for (int i = 0; i <= LAT; i++) rq[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = LAT; i > 0; i--) rq[i] = rq[i-1];
      rq[0]  = req_x;
      rgb_in = rq[LAT][2:0];
    end
  end

  // Raster model compared every cycle.
  always @(negedge clk) begin : cmp
    int p, h, v, m, fr, ex, ey, col;
    bit act, ehs, evs, ede, efs, els;
    p   = n % FRAME;
    h   = p % HT;
    v   = p / HT;
    act = (h >= HB) && (v >= VB);
    chk("req_valid", req_valid, act);
    chk("req_x", req_x, act ? h - HB : 0);
    chk("req_y", req_y, act ? v - VB : 0);
    if (n < LAT + 1) begin
      ehs = (HSYNC_POL == 0); evs = (VSYNC_POL == 0);
      ede = 0; ex = 0; ey = 0; col = 0; efs = 0; els = 0;
    end else begin
      m   = (n - LAT - 1) % FRAME;
      fr  = (n - LAT - 1) / FRAME;
      h   = m % HT;
      v   = m / HT;
      ehs = ((h >= HFP) && (h < HFP + H_PULSE)) ? (HSYNC_POL != 0) : (HSYNC_POL == 0);
      evs = ((v >= VFP) && (v < VFP + V_PULSE)) ? (VSYNC_POL != 0) : (VSYNC_POL == 0);
      ede = (h >= HB) && (v >= VB);
      ex  = ede ? h - HB : 0;
      ey  = ede ? v - VB : 0;
      col = ede ? (ex % 8) : 0;
`ifdef VGA_TEST_PATTERN_EN
      if (ede && fr < 32 && tp_hist[fr]) col = (ex / (H_ACTIVE / 8)) % 8;
`endif
      efs = (h == 0) && (v == 0);
      els = (h == 0);
    end
    chk("hsync", hsync, ehs);
    chk("vsync", vsync, evs);
    chk("de", de, ede);
    chk("x", x, ex);
    chk("y", y, ey);
    chk("rgb", {red, green, blue}, col);
    chk("frame_start", frame_start, efs);
    chk("line_start", line_start, els);
  end

  int de_frame = 0;
  int de_line  = 0;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);
    reset = 1'b0;

    for (int k = 0; k < 310; k++) begin
      @(negedge clk);
      if (n >= 3 && n < 228 && de) de_frame++;
      if (n >= 128 && n < 153 && de) de_line++;
      case (n)
        2:   chk("pin_fs_before", frame_start, 0);
        3:   begin chk("pin_fs_first", frame_start, 1); chk("pin_ls_first", line_start, 1); end
        4:   chk("pin_hs_before", hsync, 0);
        5:   chk("pin_hs_rise", hsync, 1);
        7:   chk("pin_hs_last", hsync, 1);
        8:   chk("pin_hs_fall", hsync, 0);
        137: begin chk("pin_first_de", de, 1); chk("pin_first_x", x, 0); chk("pin_first_y", y, 0); end
        142: begin chk("pin_x5", x, 5); chk("pin_rgb_x5", {red, green, blue}, 3'b101); end
        200: test_pattern = 1'b1;
        228: begin
               chk("pin_wrap_fs", frame_start, 1);
               chk("pin_wrap_ls", line_start, 1);
               chk("pin_de_per_frame", de_frame, 64);
               chk("pin_de_per_line", de_line, 16);
             end
        300: test_pattern = 1'b0;
        default: ;
      endcase
    end

    // Stage 0 is now at h=10, v=3 of frame 1: one-cycle reset.
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_n", n, 0);
    chk("mid_rst_hsync", hsync, 0);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_de", de, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_req_valid", req_valid, 0);
    chk("mid_rst_req_x", req_x, 0);
    reset = 1'b0;

    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      case (n)
        3:   chk("post_rst_fs", frame_start, 1);
        227: chk("post_rst_fs_gap", frame_start, 0);
        228: chk("post_rst_fs_next", frame_start, 1);
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
